mesi_isc_tb_ins_gen: RTL

- Stimulus generator for one testbench CPU port of the MESI ISC environment.
- Drives pseudo-random instructions (NOP, WR, RD) and addresses into a testbench CPU, and holds each instruction until the CPU acknowledges it.
- It is the driving end of the tb_ins/tb_ins_addr interface that the coherence assertion checkers observe.
- Instantiate one per CPU, each with a distinct SEED.

---
 rtl/mesi_isc_tb_ins_gen.sv | 76 +++++++
 1 files changed

// File: rtl/mesi_isc_tb_ins_gen.sv
// mesi_isc_tb_ins_gen: LFSR-driven NOP/WR/RD stimulus for one CPU port; MESI_ISC_TB_INS_GEN_HAMMER_EN restricts traffic to addresses 0/1 with no NOPs.
module mesi_isc_tb_ins_gen #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [15:0] NUM_INS     = 16'd100,
  parameter logic [3:0]  ADDR_MAX    = 4'd9,
  parameter logic [15:0] ACK_TIMEOUT = 16'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        tb_ins_ack_i,
  output logic [3:0]  tb_ins_o,
  output logic [3:0]  tb_ins_addr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] nop_cnt_o
);
  typedef enum logic [2:0] {IDLE, PICK, ISSUE, GAP, DONE, ERR} state_t;
  localparam logic [3:0] NOP = 4'd0, WR = 4'd1, RD = 4'd2;
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
  state_t state, nxt;
  logic [15:0] lfsr, lfsr_nxt, wait_cnt;
  logic [3:0] dec_ins, dec_addr;
  logic ack, to, fin, nop_pick;
  always_comb begin
    lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`ifdef MESI_ISC_TB_INS_GEN_HAMMER_EN
    dec_ins  = lfsr[2] ? RD : WR;
    dec_addr = {3'b0, lfsr[8]};
`else
    dec_ins  = (lfsr[2:0] == 3'd0) ? NOP : lfsr[2] ? RD : WR;
    dec_addr = (lfsr[11:8] > ADDR_MAX) ? lfsr[11:8] - (ADDR_MAX + 4'd1) : lfsr[11:8];
`endif
    ack      = (state == ISSUE) && tb_ins_ack_i;
    to       = (state == ISSUE) && !tb_ins_ack_i && (wait_cnt == ACK_TIMEOUT - 16'd1);
    fin      = 16'(wr_cnt_o + rd_cnt_o + nop_cnt_o) == NUM_INS;
    nop_pick = (state == PICK) && (dec_ins == NOP);
    nxt = (state == IDLE)  ? (start_i ? PICK : IDLE) :
          (state == PICK)  ? (nop_pick ? GAP : ISSUE) :
          (state == ISSUE) ? (ack ? GAP : to ? ERR : ISSUE) :
          (state == GAP)   ? (fin ? DONE : PICK) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED_EFF;
      wait_cnt      <= '0;
      tb_ins_o      <= NOP;
      tb_ins_addr_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      wr_cnt_o      <= '0;
      rd_cnt_o      <= '0;
      nop_cnt_o     <= '0;
    end else begin
      state     <= nxt;
      busy_o    <= nxt inside {PICK, ISSUE, GAP};
      done_o    <= nxt == DONE;
      timeout_o <= nxt == ERR;
      tb_ins_o  <= (nxt != ISSUE) ? NOP : (state == PICK) ? dec_ins : tb_ins_o;
      if (state == PICK && !nop_pick) begin
        tb_ins_addr_o <= dec_addr;
        wait_cnt      <= '0;
      end
      if (state == ISSUE && !ack && !to) wait_cnt <= wait_cnt + 16'd1;
      if (ack || nop_pick) lfsr <= lfsr_nxt;
      if (ack && tb_ins_o == WR) wr_cnt_o <= wr_cnt_o + 16'd1;
      if (ack && tb_ins_o == RD) rd_cnt_o <= rd_cnt_o + 16'd1;
      if (nop_pick) nop_cnt_o <= nop_cnt_o + 16'd1;
    end
  end
endmodule
